// File: rtl/demux_sel3_pkg.sv
// Shared types and helpers for the demux_sel3 loader: FSM states and step decoding.
`default_nettype none

package demux_sel3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] STEP_P1 = 2'b00;
  localparam logic [1:0] STEP_P2 = 2'b01;
  localparam logic [1:0] STEP_P4 = 2'b10;
  localparam logic [1:0] STEP_P0 = 2'b11;

  function automatic logic [2:0] step_inc(input logic [1:0] step);
    logic [2:0] inc;
    inc = 3'd1;
    case (step)
      STEP_P1: inc = 3'd1;
      STEP_P2: inc = 3'd2;
      STEP_P4: inc = 3'd4;
      STEP_P0: inc = 3'd0;
      default: inc = 3'd1;
    endcase
    return inc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_sel3_loader_lane_ptr_gen.sv
// Lane pointer and beat counter for one burst; ptr wraps modulo 8, last flags the final beat.
`default_nettype none

module lane_ptr_gen
  import demux_sel3_pkg::*;
(
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       load_i,
  input  logic       advance_i,
  input  logic [2:0] base_i,
  input  logic [2:0] len_i,
  input  logic [1:0] step_i,
  output logic [2:0] ptr_o,
  output logic       last_o
);

  logic [2:0] ptr_q, ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] inc_q, inc_d;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    inc_d = inc_q;
    if (load_i) begin
      ptr_d = base_i;
      cnt_d = len_i;
      inc_d = step_inc(step_i);
    end else if (advance_i) begin
      ptr_d = ptr_q + inc_q;
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ptr_q <= 3'd0;
      cnt_q <= 3'd0;
      inc_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      inc_q <= inc_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = (cnt_q == 3'd0);

endmodule

`default_nettype wire

// File: rtl/demux_sel3_loader.sv
// Burst sequencer driving an 8-lane registered demux; loaded lanes are held until released.
`default_nettype none

module demux_sel3_loader
  import demux_sel3_pkg::*;
#(
  parameter int RSA_DW = 16
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_base,
  input  logic [2:0]        cmd_len,
  input  logic [1:0]        cmd_step,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [RSA_DW-1:0] s_data,
  input  logic              lane_release,
  output logic              mux_en,
  output logic [2:0]        mux_sel,
  output logic [RSA_DW-1:0] mux_din,
  output logic [7:0]        lane_mask,
  output logic              busy,
  output logic              done
);

  state_e              state_q;
  logic                mux_en_q;
  logic [2:0]          mux_sel_q;
  logic [RSA_DW-1:0]   mux_din_q;
  logic [7:0]          lane_mask_q;
  logic                done_q;

  logic       w_cmd_acc;
  logic       w_beat_acc;
  logic [2:0] w_ptr;
  logic       w_last;

  // release wins over a new command while holding
  assign cmd_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && !lane_release);
  assign s_ready    = (state_q == ST_LOAD);
  assign w_cmd_acc  = cmd_valid && cmd_ready;
  assign w_beat_acc = s_valid && s_ready;

  lane_ptr_gen u_ptr (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .load_i    (w_cmd_acc),
    .advance_i (w_beat_acc),
    .base_i    (cmd_base),
    .len_i     (cmd_len),
    .step_i    (cmd_step),
    .ptr_o     (w_ptr),
    .last_o    (w_last)
  );

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= ST_IDLE;
      mux_en_q    <= 1'b0;
      mux_sel_q   <= 3'd0;
      mux_din_q   <= '0;
      lane_mask_q <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_cmd_acc) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (w_beat_acc) begin
            mux_sel_q          <= w_ptr;
            mux_din_q          <= s_data;
            mux_en_q           <= 1'b1;
            lane_mask_q[w_ptr] <= 1'b1;
            if (w_last) begin
              state_q <= ST_HOLD;
              done_q  <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (lane_release) begin
            state_q     <= ST_IDLE;
            mux_en_q    <= 1'b0;
            lane_mask_q <= 8'd0;
          end else if (w_cmd_acc) begin
            state_q <= ST_LOAD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mux_en    = mux_en_q;
  assign mux_sel   = mux_sel_q;
  assign mux_din   = mux_din_q;
  assign lane_mask = lane_mask_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_demux_sel3_loader.sv
// Directed bench for demux_sel3_loader with a behavioural 8-lane registered demux downstream.
`default_nettype none

module tb_demux_sel3_loader;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_base = 3'd0;
  logic [2:0]  cmd_len = 3'd0;
  logic [1:0]  cmd_step = 2'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = 16'd0;
  logic        lane_release = 1'b0;
  logic        mux_en;
  logic [2:0]  mux_sel;
  logic [15:0] mux_din;
  logic [7:0]  lane_mask;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  logic [15:0] dout [8];

  always #5 clk = ~clk;

  demux_sel3_loader #(.RSA_DW(16)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base     (cmd_base),
    .cmd_len      (cmd_len),
    .cmd_step     (cmd_step),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .lane_release (lane_release),
    .mux_en       (mux_en),
    .mux_sel      (mux_sel),
    .mux_din      (mux_din),
    .lane_mask    (lane_mask),
    .busy         (busy),
    .done         (done)
  );

  // downstream demux: en low clears all lanes, otherwise only lane sel is written
  always @(posedge clk) begin
    if (!mux_en) begin
      for (int k = 0; k < 8; k++) dout[k] <= 16'd0;
    end else begin
      dout[mux_sel] <= mux_din;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [2:0] base, input logic [2:0] len, input logic [1:0] step);
    cmd_valid = 1'b1; cmd_base = base; cmd_len = len; cmd_step = step;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_release();
    lane_release = 1'b1;
    tick();
    lane_release = 1'b0;
    total++;
    if (mux_en !== 1'b0 || lane_mask !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL release: en=%b mask=%h busy=%b want en=0 mask=00 busy=0", mux_en, lane_mask, busy);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (mux_en !== 1'b0 || mux_sel !== 3'd0 || mux_din !== 16'd0 || lane_mask !== 8'd0 ||
        done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: en=%b sel=%0d din=%h mask=%h done=%b busy=%b want all 0",
               mux_en, mux_sel, mux_din, lane_mask, done, busy);
    end
    tick(); tick();
    sys_rst = 1'b1;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: cmd_ready=%b s_ready=%b want 1/0", cmd_ready, s_ready);
    end
  endtask

  task automatic test_burst8();
    cmd_valid = 1'b1; cmd_base = 3'd0; cmd_len = 3'd7; cmd_step = 2'b00;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL b8_cmd_ready: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    s_valid = 1'b1; s_data = 16'h0010;
    #1;
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b1 || mux_en !== 1'b0) begin
      bad++; $display("FAIL b8_load: s_ready=%b busy=%b en=%b want 1 1 0", s_ready, busy, mux_en);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (mux_sel !== 3'(i) || mux_din !== 16'(16'h10 + i) || mux_en !== 1'b1 || done !== (i == 7)) begin
        bad++;
        $display("FAIL b8_beat%0d: sel=%0d din=%h en=%b done=%b want sel=%0d din=%h en=1 done=%b",
                 i, mux_sel, mux_din, mux_en, done, i, 16'h10 + i, (i == 7));
      end
      if (i == 7) s_valid = 1'b0;
      else s_data = 16'(16'h11 + i);
    end
    tick();
    total++;
    if (done !== 1'b0 || lane_mask !== 8'hFF || s_ready !== 1'b0 || mux_en !== 1'b1) begin
      bad++;
      $display("FAIL b8_hold: done=%b mask=%h s_ready=%b en=%b want 0 ff 0 1", done, lane_mask, s_ready, mux_en);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dout[i] !== 16'(16'h10 + i)) begin
        bad++; $display("FAIL b8_dout%0d: got %h want %h", i, dout[i], 16'h10 + i);
      end
    end
    do_release();
  endtask

  task automatic test_wrap();
    logic [2:0]  lanes [4];
    logic [15:0] vals [4];
    lanes[0] = 3'd6; lanes[1] = 3'd0; lanes[2] = 3'd2; lanes[3] = 3'd4;
    vals[0] = 16'hA0A0; vals[1] = 16'hB1B1; vals[2] = 16'hC2C2; vals[3] = 16'hD3D3;
    issue_cmd(3'd6, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = vals[i];
      tick();
      total++;
      if (mux_sel !== lanes[i] || mux_din !== vals[i]) begin
        bad++; $display("FAIL wrap_beat%0d: sel=%0d din=%h want sel=%0d din=%h", i, mux_sel, mux_din, lanes[i], vals[i]);
      end
    end
    s_valid = 1'b0;
    tick();
    total++;
    if (lane_mask !== 8'h55 || dout[6] !== 16'hA0A0 || dout[4] !== 16'hD3D3) begin
      bad++; $display("FAIL wrap_mask: mask=%h d6=%h d4=%h want 55 a0a0 d3d3", lane_mask, dout[6], dout[4]);
    end
    do_release();
  endtask

  task automatic test_stall();
    issue_cmd(3'd3, 3'd2, 2'b00);
    s_valid = 1'b1; s_data = 16'h1111;
    tick();
    s_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      total++;
      if (mux_sel !== 3'd3 || mux_din !== 16'h1111 || mux_en !== 1'b1 || lane_mask !== 8'h08 || s_ready !== 1'b1) begin
        bad++;
        $display("FAIL stall_gap%0d: sel=%0d din=%h en=%b mask=%h s_ready=%b want 3 1111 1 08 1",
                 g, mux_sel, mux_din, mux_en, lane_mask, s_ready);
      end
    end
    s_valid = 1'b1; s_data = 16'h2222;
    tick();
    s_data = 16'h3333;
    tick();
    s_valid = 1'b0;
    total++;
    if (mux_sel !== 3'd5 || mux_din !== 16'h3333 || lane_mask !== 8'h38 || done !== 1'b1) begin
      bad++; $display("FAIL stall_end: sel=%0d din=%h mask=%h done=%b want 5 3333 38 1", mux_sel, mux_din, lane_mask, done);
    end
    tick();
    do_release();
  endtask

  task automatic test_chain();
    issue_cmd(3'd1, 3'd0, 2'b00);
    s_valid = 1'b1; s_data = 16'hAAAA;
    tick();
    s_valid = 1'b0;
    cmd_valid = 1'b1; cmd_base = 3'd5; cmd_len = 3'd0; cmd_step = 2'b00;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || done !== 1'b1 || mux_sel !== 3'd1) begin
      bad++; $display("FAIL chain_hold: cmd_ready=%b done=%b sel=%0d want 1 1 1", cmd_ready, done, mux_sel);
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if (mux_en !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b1) begin
      bad++; $display("FAIL chain_reload: en=%b busy=%b s_ready=%b want 1 1 1", mux_en, busy, s_ready);
    end
    s_valid = 1'b1; s_data = 16'h5555;
    tick();
    s_valid = 1'b0;
    total++;
    if (mux_en !== 1'b1 || mux_sel !== 3'd5 || lane_mask !== 8'h22 || done !== 1'b1) begin
      bad++; $display("FAIL chain_beat: en=%b sel=%0d mask=%h done=%b want 1 5 22 1", mux_en, mux_sel, lane_mask, done);
    end
    tick();
    total++;
    if (dout[1] !== 16'hAAAA || dout[5] !== 16'h5555 || mux_en !== 1'b1) begin
      bad++; $display("FAIL chain_dout: d1=%h d5=%h en=%b want aaaa 5555 1", dout[1], dout[5], mux_en);
    end
    do_release();
  endtask

  task automatic test_release_prio();
    issue_cmd(3'd2, 3'd0, 2'b00);
    s_valid = 1'b1; s_data = 16'h4242;
    tick();
    s_valid = 1'b0;
    tick();
    lane_release = 1'b1; cmd_valid = 1'b1; cmd_base = 3'd0; cmd_len = 3'd0; cmd_step = 2'b00;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL prio_ready: cmd_ready=%b want 0", cmd_ready);
    end
    tick();
    lane_release = 1'b0;
    total++;
    if (busy !== 1'b0 || mux_en !== 1'b0 || lane_mask !== 8'h00 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL prio_idle: busy=%b en=%b mask=%h done=%b cmd_ready=%b want 0 0 00 0 1",
               busy, mux_en, lane_mask, done, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      bad++; $display("FAIL prio_accept: busy=%b s_ready=%b want 1 1", busy, s_ready);
    end
    s_valid = 1'b1; s_data = 16'h0101;
    tick();
    s_valid = 1'b0;
    tick();
    do_release();
  endtask

  task automatic test_async_reset();
    issue_cmd(3'd0, 3'd3, 2'b00);
    s_valid = 1'b1; s_data = 16'h7777;
    tick();
    s_data = 16'h8888;
    tick();
    s_valid = 1'b0;
    #2;
    sys_rst = 1'b0;
    #1;
    total++;
    if (mux_en !== 1'b0 || mux_sel !== 3'd0 || mux_din !== 16'd0 || lane_mask !== 8'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: en=%b sel=%0d din=%h mask=%h busy=%b done=%b want all 0",
               mux_en, mux_sel, mux_din, lane_mask, busy, done);
    end
    #2;
    sys_rst = 1'b1;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || dout[1] !== 16'd0) begin
      bad++;
      $display("FAIL post_rst: cmd_ready=%b busy=%b s_ready=%b d1=%h want 1 0 0 0000",
               cmd_ready, busy, s_ready, dout[1]);
    end
  endtask

  initial begin
    test_reset();
    test_burst8();
    test_wrap();
    test_stall();
    test_chain();
    test_release_prio();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
